alu_16bit_core: RTL and testbench

//  16-bit integer ALU with registered result and status flags (carry, borrow, overflow, zero).

---
 rtl/alu_16bit_core.sv | 109 ++++++++++
 tb/tb_alu_16bit_core.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/alu_16bit_core.sv
// 16-bit integer ALU execute stage: one opcode per clock, registered result
// and carry/borrow/overflow/zero flags, synchronous active-high reset.
module alu_16bit_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_sel,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_AND  = 4'b0010, OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100, OP_SHL  = 4'b0101, OP_SHR  = 4'b0110, OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000, OP_NOT  = 4'b1001, OP_NAND = 4'b1010, OP_NOR  = 4'b1011,
    OP_XNOR = 4'b1100, OP_INC  = 4'b1101, OP_DEC  = 4'b1110, OP_PASS = 4'b1111
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] arith_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [3:0]       shamt;

  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d, carry_q;
  logic             borrow_d, borrow_q;
  logic             overflow_d, overflow_q;
  logic             zero_d, zero_q;

  assign op    = op_e'(alu_sel);
  assign shamt = b[3:0];

  // INC/DEC share the ADD/SUB datapath with the second operand forced to 1
  always_comb begin
    arith_b = b;
    if (op == OP_INC || op == OP_DEC) arith_b = WIDTH'(1);
  end

  assign sum  = {1'b0, a} + {1'b0, arith_b};
  assign diff = {1'b0, a} - {1'b0, arith_b};

  always_comb begin
    result_d   = '0;
    carry_d    = 1'b0;
    borrow_d   = 1'b0;
    overflow_d = 1'b0;
    case (op)
      OP_ADD, OP_INC: begin
        result_d   = sum[WIDTH-1:0];
        carry_d    = sum[WIDTH];
        overflow_d = (a[WIDTH-1] == arith_b[WIDTH-1]) &&
                     (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        result_d   = diff[WIDTH-1:0];
        borrow_d   = diff[WIDTH];
        overflow_d = (a[WIDTH-1] != arith_b[WIDTH-1]) &&
                     (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result_d = a & b;
      OP_OR:   result_d = a | b;
      OP_XOR:  result_d = a ^ b;
      OP_SHL:  result_d = a << shamt;
      OP_SHR:  result_d = a >> shamt;
      OP_SRA:  result_d = WIDTH'($signed(a) >>> shamt);
      OP_SLT: begin
        result_d = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
        borrow_d = diff[WIDTH];
      end
      OP_NOT:  result_d = ~a;
      OP_NAND: result_d = ~(a & b);
      OP_NOR:  result_d = ~(a | b);
      OP_XNOR: result_d = ~(a ^ b);
      OP_PASS: result_d = a;
      default: result_d = '0;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= '0;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      result_q   <= result_d;
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign result   = result_q;
  assign carry    = carry_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_alu_16bit_core.sv
// Bench for alu_16bit_core: directed corner ops, then random back-to-back ops
// with random resets, all checked against an integer-arithmetic reference.
module tb_alu_16bit_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic [3:0]  alu_sel;
  logic [15:0] result;
  logic        carry, borrow, overflow, zero;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [15:0] r;
    logic        c, bo, v, z;
  } exp_t;

  alu_16bit_core #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .alu_sel(alu_sel),
    .result(result), .carry(carry), .borrow(borrow),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic, range tests for signed overflow
  function automatic exp_t model(input logic [15:0] ia, input logic [15:0] ib, input logic [3:0] op);
    exp_t e;
    int ua, ub, sa, sb, n, s;
    e  = '0;
    ua = int'(ia);
    ub = int'(ib);
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    n  = int'(ib[3:0]);
    if (op == 4'd13) begin ub = 1; sb = 1; end
    if (op == 4'd14) begin ub = 1; sb = 1; end
    case (op)
      4'd0, 4'd13: begin
        s = ua + ub; e.r = s[15:0]; e.c = (s > 65535);
        e.v = (sa + sb > 32767) || (sa + sb < -32768);
      end
      4'd1, 4'd14: begin
        s = ua - ub; e.r = s[15:0]; e.bo = (ua < ub);
        e.v = (sa - sb > 32767) || (sa - sb < -32768);
      end
      4'd2:  e.r = ia & ib;
      4'd3:  e.r = ia | ib;
      4'd4:  e.r = ia ^ ib;
      4'd5:  begin s = ua << n; e.r = s[15:0]; end
      4'd6:  begin s = ua >> n; e.r = s[15:0]; end
      4'd7:  begin s = sa >>> n; e.r = s[15:0]; end
      4'd8:  begin e.r = (sa < sb) ? 16'd1 : 16'd0; e.bo = (ua < ub); end
      4'd9:  e.r = ~ia;
      4'd10: e.r = ~(ia & ib);
      4'd11: e.r = ~(ia | ib);
      4'd12: e.r = ~(ia ^ ib);
      default: e.r = ia;
    endcase
    e.z = (e.r == 16'd0);
    return e;
  endfunction

  function automatic exp_t reset_val();
    exp_t e;
    e = '0;
    e.z = 1'b1;
    return e;
  endfunction

  // Drive one op (optionally with reset), clock it, check 1 edge later
  task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input logic [3:0] op, input logic r);
    exp_t e;
    a = ia; b = ib; alu_sel = op; rst = r;
    e = r ? reset_val() : model(ia, ib, op);
    @(posedge clk);
    #1;
    chk({tag, ".res"}, {16'd0, result}, {16'd0, e.r});
    chk({tag, ".flg"}, {28'd0, carry, borrow, overflow, zero}, {28'd0, e.c, e.bo, e.v, e.z});
  endtask

  logic [15:0] da [20] = '{16'd0, 16'd20, 16'd20, 16'd10, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF,
                           16'h0001, 16'h8000, 16'h8000, 16'h0001, 16'd5, 16'd15, 16'hFFFF,
                           16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000};
  logic [15:0] db [20] = '{16'd0, 16'd10, 16'd10, 16'd10, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0000,
                           16'd4, 16'd3, 16'd3, 16'h0014, 16'd10, 16'd10, 16'd1,
                           16'd1, 16'd1, 16'd1, 16'd0, 16'd0};
  logic [3:0]  dop [20] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd9,
                            4'd5, 4'd6, 4'd7, 4'd5, 4'd8, 4'd8, 4'd8,
                            4'd0, 4'd1, 4'd0, 4'd14, 4'd14};

  initial begin
    exp_t e;
    logic [15:0] held;
    a = '0; b = '0; alu_sel = '0; rst = 1'b1;

    run_op("reset", 16'h1234, 16'h5678, 4'd0, 1'b1);
    for (int i = 1; i < 20; i++) run_op($sformatf("dir%0d", i), da[i], db[i], dop[i], 1'b0);

    // Independent constants for the headline boundaries
    run_op("ffff_p1", 16'hFFFF, 16'd1, 4'd0, 1'b0);
    chk("ffff_p1.abs", {12'd0, result, carry, borrow, overflow, zero}, {12'd0, 16'h0000, 4'b1001});
    run_op("zero_m1", 16'h0000, 16'd1, 4'd1, 1'b0);
    chk("zero_m1.abs", {12'd0, result, carry, borrow, overflow, zero}, {12'd0, 16'hFFFF, 4'b0100});
    run_op("inc_max", 16'hFFFF, 16'h0000, 4'd13, 1'b0);
    run_op("inc_ovf", 16'h7FFF, 16'h0000, 4'd13, 1'b0);

    // Mid-cycle input changes must not leak into the registered outputs
    run_op("hold", 16'h0F0F, 16'h00FF, 4'd2, 1'b0);
    held = result;
    a = 16'hAAAA; b = 16'h5555; alu_sel = 4'd3;
    #3;
    chk("hold.mid", {16'd0, result}, {16'd0, held});

    // Reset mid-stream discards the op in that cycle
    run_op("pre_rst", 16'd100, 16'd200, 4'd0, 1'b0);
    run_op("mid_rst", 16'd100, 16'd200, 4'd0, 1'b1);
    run_op("post_rst", 16'h8000, 16'd5, 4'd7, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] ra, rb;
      logic [3:0]  rop;
      logic        rr;
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = 4'($urandom_range(0, 15));
      rr  = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h8000;
      if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) != 0) ? 16'h0001 : 16'h7FFF;
      run_op($sformatf("rnd%0d", i), ra, rb, rop, rr);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
